spmem_paged: RTL and testbench

//  Synthesisable sparse memory. Backs a 2**AddrWidth byte address space with NumPages physical pages.

---
 rtl/spmem_paged.sv | 274 +++++++++++++++++++++++++++
 tb/tb_spmem_paged.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmem_paged.sv
// ============================================================================
//  Module      : spmem_paged
//  Description : Sparse paged memory. A 2**AddrWidth byte space is backed by
//                NumPages physical pages, allocated on first write through a
//                small tag CAM. Unwritten addresses read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spmem_pkj;
    typedef enum logic [1:0] {
        OP_BYTE  = 2'd0,
        OP_HALF  = 2'd1,
        OP_WORD  = 2'd2,
        OP_DWORD = 2'd3
    } rwop_e;
    typedef logic [63:0] addr_t;
    typedef logic [63:0] data_t;
endpackage

module spmem_paged
    import spmem_pkj::*;
#(
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 64,
    parameter int NumPages    = 8,
    parameter int PageOffBits = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic                            req_we_i,
    input  rwop_e                           req_op_i,
    input  logic                            req_unsigned_i,
    input  logic [AddrWidth-1:0]            req_addr_i,
    input  logic [DataWidth-1:0]            req_wdata_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [DataWidth-1:0]            rsp_rdata_o,
    output logic                            rsp_err_o,
    output logic                            rsp_hit_o,
    output logic [$clog2(NumPages+1)-1:0]   pages_used_o
);

    localparam int PAGE_BYTES = 1 << PageOffBits;
    localparam int DW_BYTES   = DataWidth / 8;
    localparam int TAG_W      = AddrWidth - PageOffBits;
    localparam int IDX_W      = (NumPages > 1) ? $clog2(NumPages) : 1;
    localparam int CNT_W      = $clog2(NumPages + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    // Captured request
    logic                   r_we;
    rwop_e                  r_op;
    logic                   r_unsigned;
    logic [AddrWidth-1:0]   r_addr;
    logic [DataWidth-1:0]   r_wdata;
    logic                   r_hit;
    logic [IDX_W-1:0]       r_hit_idx;

    // Page directory
    logic [NumPages-1:0]    r_valid;
    logic [TAG_W-1:0]       r_tag [NumPages];
    logic [CNT_W-1:0]       r_used;

    // Page storage (not reset; validity is tracked by r_valid)
    logic [7:0]             r_mem [NumPages][PAGE_BYTES];

    // Response
    logic                   r_rsp_valid;
    logic [DataWidth-1:0]   r_rsp_rdata;
    logic                   r_rsp_err;
    logic                   r_rsp_hit;

    // Combinational helpers
    logic                   w_handshake;
    logic                   w_flush;
    logic [TAG_W-1:0]       w_req_tag;
    logic                   w_lkp_hit;
    logic [IDX_W-1:0]       w_lkp_idx;
    logic [IDX_W-1:0]       w_alloc_idx;
    logic                   w_full;
    logic [31:0]            w_nbytes;
    logic                   w_misal;
    logic                   w_err;
    logic                   w_do_write;
    logic                   w_do_alloc;
    logic [IDX_W-1:0]       w_acc_idx;
    logic [PageOffBits-1:0] w_off;
    logic [DataWidth-1:0]   w_raw;
    logic [DataWidth-1:0]   w_ext;
    logic                   w_sign;

    assign req_ready_o  = (r_state == S_IDLE) && !flush_i;
    assign w_handshake  = req_valid_i && req_ready_o;
    assign w_flush      = (r_state == S_IDLE) && flush_i;
    assign w_req_tag    = req_addr_i[AddrWidth-1:PageOffBits];
    assign w_full       = &r_valid;
    assign w_nbytes     = 32'd1 << r_op;
    assign w_off        = r_addr[PageOffBits-1:0];
    assign w_err        = w_misal
                        || ((r_op == OP_DWORD) && (DataWidth == 32))
                        || (r_we && !r_hit && w_full);
    assign w_do_write   = (r_state == S_LOOKUP) && r_we && !w_err;
    assign w_do_alloc   = w_do_write && !r_hit;
    assign w_acc_idx    = r_hit ? r_hit_idx : w_alloc_idx;

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_rdata_o  = r_rsp_rdata;
    assign rsp_err_o    = r_rsp_err;
    assign rsp_hit_o    = r_rsp_hit;
    assign pages_used_o = r_used;

    // Tag CAM search of the incoming request address
    always_comb begin
        w_lkp_hit = 1'b0;
        w_lkp_idx = '0;
        for (int p = NumPages - 1; p >= 0; p--) begin
            if (r_valid[p] && (r_tag[p] == w_req_tag)) begin
                w_lkp_hit = 1'b1;
                w_lkp_idx = IDX_W'(p);
            end
        end
    end

    // Lowest-index free page for allocation
    always_comb begin
        w_alloc_idx = '0;
        for (int p = NumPages - 1; p >= 0; p--) begin
            if (!r_valid[p]) begin
                w_alloc_idx = IDX_W'(p);
            end
        end
    end

    // Natural-alignment check for the access size
    always_comb begin
        w_misal = 1'b0;
        case (r_op)
            OP_HALF:  w_misal = r_addr[0];
            OP_WORD:  w_misal = |r_addr[1:0];
            OP_DWORD: w_misal = |r_addr[2:0];
            default:  w_misal = 1'b0;
        endcase
    end

    // Read-data gather and sign/zero extension
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < DW_BYTES; i++) begin
            if (i < w_nbytes) begin
                w_raw[8*i +: 8] = r_mem[r_hit_idx][w_off + PageOffBits'(i)];
            end
        end
        case (r_op)
            OP_BYTE: w_sign = w_raw[7];
            OP_HALF: w_sign = w_raw[15];
            OP_WORD: w_sign = w_raw[31];
            default: w_sign = w_raw[DataWidth-1];
        endcase
        w_sign = w_sign && !r_unsigned;
        w_ext  = w_raw;
        for (int i = 0; i < DW_BYTES; i++) begin
            if (i >= w_nbytes) begin
                w_ext[8*i +: 8] = {8{w_sign}};
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_handshake) w_state_nxt = S_LOOKUP;
            S_LOOKUP: w_state_nxt = S_RESP;
            S_RESP:   if (rsp_ready_i) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the request and its CAM result on handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we       <= 1'b0;
            r_op       <= OP_BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_hit      <= 1'b0;
            r_hit_idx  <= '0;
        end else if (w_handshake) begin
            r_we       <= req_we_i;
            r_op       <= req_op_i;
            r_unsigned <= req_unsigned_i;
            r_addr     <= req_addr_i;
            r_wdata    <= req_wdata_i;
            r_hit      <= w_lkp_hit;
            r_hit_idx  <= w_lkp_idx;
        end
    end

    // Page directory: flush clears everything, allocation claims a page
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            r_used  <= '0;
            for (int p = 0; p < NumPages; p++) begin
                r_tag[p] <= '0;
            end
        end else if (w_flush) begin
            r_valid <= '0;
            r_used  <= '0;
        end else if (w_do_alloc) begin
            r_valid[w_alloc_idx] <= 1'b1;
            r_tag[w_alloc_idx]   <= r_addr[AddrWidth-1:PageOffBits];
            r_used               <= r_used + CNT_W'(1);
        end
    end

    // Page storage: fresh pages are zero-filled, then the write bytes merged
    always_ff @(posedge clk_i) begin
        if (w_do_write) begin
            if (w_do_alloc) begin
                for (int b = 0; b < PAGE_BYTES; b++) begin
                    r_mem[w_acc_idx][b] <= 8'h00;
                end
            end
            for (int i = 0; i < DW_BYTES; i++) begin
                if (i < w_nbytes) begin
                    r_mem[w_acc_idx][w_off + PageOffBits'(i)] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response register, held stable until accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_hit   <= 1'b0;
        end else if (r_state == S_LOOKUP) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_hit   <= r_hit;
            r_rsp_rdata <= (w_err || r_we || !r_hit) ? '0 : w_ext;
        end else if ((r_state == S_RESP) && rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spmem_paged.sv
// ============================================================================
//  Module      : tb_spmem_paged
//  Description : Directed self-checking bench for spmem_paged (64-bit and a
//                32-bit data-width instance).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spmem_paged;
    import spmem_pkj::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    rwop_e       req_op;
    logic        req_uns;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_hit;
    logic [3:0]  pages_used;

    logic        r32_valid;
    logic        r32_ready;
    logic        r32_we;
    rwop_e       r32_op;
    logic [31:0] r32_addr;
    logic [31:0] r32_wdata;
    logic        r32_rsp_valid;
    logic [31:0] r32_rdata;
    logic        r32_err;
    logic        r32_hit;
    logic [3:0]  r32_used;

    int n_checks = 0;
    int n_errors = 0;

    spmem_paged #(.AddrWidth(32), .DataWidth(64), .NumPages(8), .PageOffBits(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_op_i(req_op), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .rsp_hit_o(rsp_hit),
        .pages_used_o(pages_used)
    );

    spmem_paged #(.AddrWidth(32), .DataWidth(32), .NumPages(8), .PageOffBits(8)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0),
        .req_valid_i(r32_valid), .req_ready_o(r32_ready), .req_we_i(r32_we),
        .req_op_i(r32_op), .req_unsigned_i(1'b1), .req_addr_i(r32_addr),
        .req_wdata_i(r32_wdata), .rsp_valid_o(r32_rsp_valid), .rsp_ready_i(1'b1),
        .rsp_rdata_o(r32_rdata), .rsp_err_o(r32_err), .rsp_hit_o(r32_hit),
        .pages_used_o(r32_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // One full request/response on the 64-bit instance
    task automatic do_req(input logic we, input rwop_e op, input logic uns,
                          input logic [31:0] addr, input logic [63:0] wd,
                          output logic [63:0] rd, output logic err,
                          output logic hit, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_op = op; req_uns = uns;
        req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_val("hs_timeout", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata; err = rsp_err; hit = rsp_hit;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b1;
        #1 check_val("flush_ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
    endtask

    // One request on the 32-bit instance
    task automatic req32(input logic we, input rwop_e op, input logic [31:0] addr,
                         input logic [31:0] wd, output logic err);
        int n;
        @(negedge clk);
        r32_valid = 1'b1; r32_we = we; r32_op = op; r32_addr = addr; r32_wdata = wd;
        @(posedge clk);
        #1 r32_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!r32_rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_val("r32_lat", 64'(n), 64'd2);
        err = r32_err;
    endtask

    logic [63:0] rd;
    logic        err, hit;
    int          lat;

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_op = OP_BYTE; req_uns = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        r32_valid = 1'b0; r32_we = 1'b0; r32_op = OP_BYTE; r32_addr = '0; r32_wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset state and read miss
        check_val("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_val("rst_used", 64'(pages_used), 64'd0);
        check_val("rst_ready", {63'd0, req_ready}, 64'd1);
        do_req(1'b0, OP_DWORD, 1'b0, 32'h1000, 64'd0, rd, err, hit, lat);
        check_val("t1_lat", 64'(lat), 64'd2);
        check_val("t1_rdata", rd, 64'd0);
        check_val("t1_hit", {63'd0, hit}, 64'd0);
        check_val("t1_err", {63'd0, err}, 64'd0);
        check_val("t1_used", 64'(pages_used), 64'd0);

        // 2: half write, signed/unsigned reads, zero-filled page
        do_req(1'b1, OP_HALF, 1'b0, 32'h2002, 64'h8001, rd, err, hit, lat);
        check_val("t2_wr_err", {63'd0, err}, 64'd0);
        check_val("t2_wr_hit", {63'd0, hit}, 64'd0);
        check_val("t2_wr_rdata", rd, 64'd0);
        check_val("t2_used", 64'(pages_used), 64'd1);
        do_req(1'b0, OP_HALF, 1'b0, 32'h2002, 64'd0, rd, err, hit, lat);
        check_val("t2_rd_s", rd, 64'hFFFF_FFFF_FFFF_8001);
        check_val("t2_rd_hit", {63'd0, hit}, 64'd1);
        do_req(1'b0, OP_HALF, 1'b1, 32'h2002, 64'd0, rd, err, hit, lat);
        check_val("t2_rd_u", rd, 64'h0000_0000_0000_8001);
        do_req(1'b0, OP_BYTE, 1'b0, 32'h2000, 64'd0, rd, err, hit, lat);
        check_val("t2_rd_zero", rd, 64'd0);
        do_req(1'b0, OP_WORD, 1'b0, 32'h2000, 64'd0, rd, err, hit, lat);
        check_val("t2_rd_word_s", rd, 64'hFFFF_FFFF_8001_0000);
        do_req(1'b1, OP_BYTE, 1'b0, 32'h2003, 64'h12, rd, err, hit, lat);
        check_val("t2_bwr_hit", {63'd0, hit}, 64'd1);
        do_req(1'b0, OP_HALF, 1'b1, 32'h2002, 64'd0, rd, err, hit, lat);
        check_val("t2_merge", rd, 64'h1201);

        // 3: fill all pages, overflow, resident write
        do_flush();
        check_val("t3_flush_used", 64'(pages_used), 64'd0);
        for (int k = 0; k < 9; k++) begin
            do_req(1'b1, OP_BYTE, 1'b0, 32'h10000 + 32'(k) * 32'h100, 64'(k + 1),
                   rd, err, hit, lat);
            check_val($sformatf("t3_err%0d", k), {63'd0, err}, (k == 8) ? 64'd1 : 64'd0);
        end
        check_val("t3_used", 64'(pages_used), 64'd8);
        do_req(1'b1, OP_BYTE, 1'b0, 32'h10305, 64'hAA, rd, err, hit, lat);
        check_val("t3_res_err", {63'd0, err}, 64'd0);
        check_val("t3_res_hit", {63'd0, hit}, 64'd1);
        check_val("t3_used2", 64'(pages_used), 64'd8);
        do_req(1'b0, OP_BYTE, 1'b1, 32'h10300, 64'd0, rd, err, hit, lat);
        check_val("t3_rd_p3", rd, 64'd4);
        do_req(1'b0, OP_BYTE, 1'b1, 32'h10305, 64'd0, rd, err, hit, lat);
        check_val("t3_rd_aa", rd, 64'hAA);
        do_req(1'b0, OP_BYTE, 1'b1, 32'h10800, 64'd0, rd, err, hit, lat);
        check_val("t3_rd_p9_hit", {63'd0, hit}, 64'd0);
        check_val("t3_rd_p9", rd, 64'd0);

        // 4: misaligned accesses and DWORD on a 32-bit instance
        do_flush();
        do_req(1'b1, OP_WORD, 1'b0, 32'h3002, 64'h1122_3344, rd, err, hit, lat);
        check_val("t4_word_err", {63'd0, err}, 64'd1);
        do_req(1'b1, OP_HALF, 1'b0, 32'h3001, 64'h5566, rd, err, hit, lat);
        check_val("t4_half_err", {63'd0, err}, 64'd1);
        check_val("t4_used", 64'(pages_used), 64'd0);
        do_req(1'b0, OP_WORD, 1'b0, 32'h3002, 64'd0, rd, err, hit, lat);
        check_val("t4_rd_err", {63'd0, err}, 64'd1);
        check_val("t4_rd_data", rd, 64'd0);
        req32(1'b1, OP_DWORD, 32'h4000, 32'hDEAD_BEEF, err);
        check_val("t4_dw32_err", {63'd0, err}, 64'd1);
        check_val("t4_dw32_used", 64'(r32_used), 64'd0);
        req32(1'b1, OP_WORD, 32'h4000, 32'hDEAD_BEEF, err);
        check_val("t4_w32_err", {63'd0, err}, 64'd0);
        check_val("t4_w32_used", 64'(r32_used), 64'd1);

        // 5: back-pressure, flush ignored outside IDLE, flush in IDLE
        do_req(1'b1, OP_WORD, 1'b0, 32'h5000, 64'hDEAD_BEEF, rd, err, hit, lat);
        check_val("t5_used", 64'(pages_used), 64'd1);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_op = OP_WORD; req_uns = 1'b1;
        req_addr = 32'h5000;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) flush = 1'b1;
            if (k == 3) flush = 1'b0;
            @(negedge clk);
            check_val($sformatf("t5_hold_valid%0d", k), {63'd0, rsp_valid}, 64'd1);
            check_val($sformatf("t5_hold_data%0d", k), rsp_rdata, 64'hDEAD_BEEF);
            check_val($sformatf("t5_hold_ready%0d", k), {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check_val("t5_released", {63'd0, rsp_valid}, 64'd0);
        check_val("t5_used_kept", 64'(pages_used), 64'd1);
        do_flush();
        check_val("t5_flush_used", 64'(pages_used), 64'd0);
        do_req(1'b0, OP_WORD, 1'b1, 32'h5000, 64'd0, rd, err, hit, lat);
        check_val("t5_rd_after_flush", rd, 64'd0);
        check_val("t5_hit_after_flush", {63'd0, hit}, 64'd0);

        // 6: reset during LOOKUP of a write miss
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_op = OP_BYTE; req_addr = 32'h6000;
        req_wdata = 64'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_val("t6_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_val("t6_used", 64'(pages_used), 64'd0);
        repeat (2) @(negedge clk);
        check_val("t6_no_rsp", {63'd0, rsp_valid}, 64'd0);
        do_req(1'b0, OP_BYTE, 1'b1, 32'h6000, 64'd0, rd, err, hit, lat);
        check_val("t6_rd", rd, 64'd0);
        check_val("t6_hit", {63'd0, hit}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
